// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RISC-V instruction field decoder between fetch
// and register-file read. Extracts rs1/rs2/rd, format class and an XLEN-wide
// sign-extended immediate, flags illegal encodings and counts them.
//
// Optional feature macro: DECODE_SKID_EN
//   defined   -> output register plus skid register; in_ready comes straight
//                from a flop (skid empty) with no path from out_ready.
//   undefined -> single output register; in_ready = !out_valid || out_ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid keeps its data stable until the transfer, and
// while out_valid && !out_ready every out_* signal holds its value.
module rv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_ra,
    output logic [4:0]       out_rb,
    output logic [4:0]       out_rw,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      ra;
        logic [4:0]      rb;
        logic [4:0]      rw;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t           dec;
    entry_t           out_q;
    logic             out_valid_q;
    logic [31:0]      imm32;
    logic [CNT_W-1:0] cnt_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // Combinational field decode of the offered word; unused fields stay zero.
    always_comb begin
        dec         = '0;
        imm32       = '0;
        dec.pc      = in_pc;
        dec.opcode  = in_instr[6:0];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (in_instr[6:0])
                OP_R: begin
                    dec.fmt = FMT_R;
                    dec.ra  = in_instr[19:15];
                    dec.rb  = in_instr[24:20];
                    dec.rw  = in_instr[11:7];
                end
                OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                    dec.fmt = FMT_I;
                    dec.ra  = in_instr[19:15];
                    dec.rw  = in_instr[11:7];
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                OP_STORE: begin
                    dec.fmt = FMT_S;
                    dec.ra  = in_instr[19:15];
                    dec.rb  = in_instr[24:20];
                    imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                OP_BRANCH: begin
                    dec.fmt = FMT_B;
                    dec.ra  = in_instr[19:15];
                    dec.rb  = in_instr[24:20];
                    imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    dec.fmt = FMT_U;
                    dec.rw  = in_instr[11:7];
                    imm32   = {in_instr[31:12], 12'b0};
                end
                OP_JAL: begin
                    dec.fmt = FMT_J;
                    dec.rw  = in_instr[11:7];
                    imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        // Every 32-bit immediate above already carries instr[31] in bit 31,
        // so widening by replicating bit 31 matches sign extension from instr[31].
        dec.imm       = {XLEN{imm32[31]}};
        dec.imm[31:0] = imm32;
    end

`ifdef DECODE_SKID_EN
    entry_t skid_q;
    logic   skid_empty_q;

    // in_ready is the skid-empty flop itself: no path from out_ready.
    assign in_ready = skid_empty_q;

    // Output register plus skid register; skid content always drains first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            out_q.fmt    <= FMT_NONE;
            skid_q       <= '0;
            skid_empty_q <= 1'b1;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_empty_q <= 1'b1;
        end else if (!skid_empty_q) begin
            if (out_fire) begin
                out_q        <= skid_q;
                skid_empty_q <= 1'b1;
            end
        end else if (in_fire) begin
            if (!out_valid_q || out_fire) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                skid_q       <= dec;
                skid_empty_q <= 1'b0;
            end
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end
`else
    // Accept when the output register is empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;

    // Single output register; a new entry replaces a draining one in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_q.fmt   <= FMT_NONE;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    // Saturating illegal counter; inputs dropped by flush are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!flush && in_fire && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_q.pc;
    assign out_imm       = out_q.imm;
    assign out_ra        = out_q.ra;
    assign out_rb        = out_q.rb;
    assign out_rw        = out_q.rw;
    assign out_opcode    = out_q.opcode;
    assign out_funct3    = out_q.funct3;
    assign out_funct7    = out_q.funct7;
    assign out_fmt       = out_q.fmt;
    assign out_illegal   = out_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed bench for rv_decode_stage. A 32-bit instance is
// fully checked; a 64-bit instance shares the inputs to check wide sign extension.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  out_ra, out_rb, out_rw;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_in_pc, w_out_pc, w_out_imm;
    logic [4:0]  w_ra, w_rb, w_rw;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3, w_fmt;
    logic [7:0]  w_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    assign w_in_pc = {32'h0, in_pc};

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    rv_decode_stage #(.XLEN(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_ra(out_ra), .out_rb(out_rb), .out_rw(out_rw),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    rv_decode_stage #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_pc(w_in_pc),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc), .out_imm(w_out_imm),
        .out_ra(w_ra), .out_rb(w_rb), .out_rw(w_rw),
        .out_opcode(w_opcode), .out_funct3(w_funct3), .out_funct7(w_funct7),
        .out_fmt(w_fmt), .out_illegal(w_out_illegal), .illegal_count(w_count)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic [31:0] imm, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [4:0] rw,
                           input logic [2:0] fmt, input logic ill);
        chk({tag, "_valid"},   64'(out_valid),   64'(1'b1));
        chk({tag, "_imm"},     64'(out_imm),     64'(imm));
        chk({tag, "_ra"},      64'(out_ra),      64'(ra));
        chk({tag, "_rb"},      64'(out_rb),      64'(rb));
        chk({tag, "_rw"},      64'(out_rw),      64'(rw));
        chk({tag, "_fmt"},     64'(out_fmt),     64'(fmt));
        chk({tag, "_illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    initial begin
        logic [31:0] held_pc;
        int sent;
        int got;
        held_pc = '0;

        // reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_rw", 64'(out_rw), 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd7);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_count", 64'(illegal_count), 64'd0);

        // addi x1,x2,-1
        send(32'hFFF10093, 32'h100);
        chk_dec("addi", 32'hFFFFFFFF, 5'd2, 5'd0, 5'd1, 3'd1, 1'b0);
        chk("addi_pc", 64'(out_pc), 64'h100);
        chk("addi_opcode", 64'(out_opcode), 64'h13);
        chk("addi_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_pc64", w_out_pc, 64'h100);

        // beq x0,x0,-4
        send(32'hFE000EE3, 32'h104);
        chk_dec("beq", 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 3'd3, 1'b0);
        chk("beq_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFC);

        // lui x1,0x12345
        send(32'h123450B7, 32'h108);
        chk_dec("lui", 32'h12345000, 5'd0, 5'd0, 5'd1, 3'd4, 1'b0);
        chk("lui_imm64", w_out_imm, 64'h0000000012345000);

        // sw x5,-8(x2)
        send(32'hFE512C23, 32'h10C);
        chk_dec("sw", 32'hFFFFFFF8, 5'd2, 5'd5, 5'd0, 3'd2, 1'b0);
        chk("sw_funct3", 64'(out_funct3), 64'd2);

        // jal x1,+8
        send(32'h008000EF, 32'h110);
        chk_dec("jal", 32'h00000008, 5'd0, 5'd0, 5'd1, 3'd5, 1'b0);

        // sub x3,x1,x2
        send(32'h402081B3, 32'h114);
        chk_dec("sub", 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0);
        chk("sub_funct7", 64'(out_funct7), 64'h20);

        // illegal encodings
        send(32'h00000000, 32'h118);
        chk_dec("ill_zero", 32'h0, 5'd0, 5'd0, 5'd0, 3'd7, 1'b1);
        chk("ill_zero_count", 64'(illegal_count), 64'd1);
        send(32'hFFF10091, 32'h11C);
        chk_dec("ill_low2", 32'h0, 5'd0, 5'd0, 5'd0, 3'd7, 1'b1);
        send(32'h0000000F, 32'h120);
        chk_dec("ill_opc", 32'h0, 5'd0, 5'd0, 5'd0, 3'd7, 1'b1);
        chk("ill_count3", 64'(illegal_count), 64'd3);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // backpressure stream with scoreboard
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (sent < 4);
            in_instr  = 32'hFFF10093;
            in_pc     = 32'(sent * 4);
            #1;
            if (cyc == 2) held_pc = out_pc;
            if (cyc == 3 || cyc == 4) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_pc", 64'(out_pc), 64'(held_pc));
            end
`ifdef DECODE_SKID_EN
            if (cyc == 2) chk("bp_ready_skid_free", 64'(in_ready), 64'd1);
            if (cyc == 3) chk("bp_ready_both_full", 64'(in_ready), 64'd0);
`else
            if (cyc == 2) chk("bp_ready_stalled", 64'(in_ready), 64'd0);
`endif
            if (in_valid && in_ready) begin
                exp_q.push_back(in_pc);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp_extra_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("bp_order", 64'(out_pc), 64'(exp_q.pop_front()));
                end
                got++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(got), 64'd4);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
        chk("bp_no_dup", 64'(out_valid), 64'd0);

        // flush with storage full and an illegal word offered
        out_ready = 1'b0;
        send(32'hFFF10093, 32'h200);
        send(32'hFFF10093, 32'h204);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00000000;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_count", 64'(illegal_count), 64'd3);
        tick();
        chk("flush_no_ghost", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // saturation
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        for (int i = 0; i < 251; i++) tick();
        chk("sat_254", 64'(illegal_count), 64'd254);
        for (int i = 0; i < 49; i++) tick();
        chk("sat_255", 64'(illegal_count), 64'd255);
        chk("sat_count64", 64'(w_count), 64'd255);

        // reset mid-stream
        in_instr = 32'hFFF10093;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        chk("rst2_imm", 64'(out_imm), 64'd0);
        chk("rst2_ra", 64'(out_ra), 64'd0);
        chk("rst2_fmt", 64'(out_fmt), 64'd7);
        chk("rst2_count", 64'(illegal_count), 64'd0);
        chk("rst2_imm64", w_out_imm, 64'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered, parametrised RISC-V instruction field decoder for the processor datapath. It sits between instruction fetch and register-file read. For each accepted instruction it extracts source/destination register indices, format class and a sign-extended immediate of width XLEN. The stage uses a valid/ready handshake and an optional skid buffer, so backpressure from the execute side never drops or reorders instructions. It also flags illegal encodings and counts them.

## Interface
- XLEN, 32, datapath/immediate width; legal values 32 or 64
- CNT_W, 8, width of illegal-instruction counter
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded entry presented
- out_ready  in  1  execute side accepts
- out_pc  out  XLEN  PC carried through
- out_imm  out  XLEN  sign-extended immediate
- out_ra / out_rb / out_rw  out  5 each  rs1, rs2, rd
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=7
- out_illegal  out  1  entry is an illegal encoding
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- Decode by opcode:
  - R 0110011: ra=rs1, rb=rs2, rw=rd, imm=0.
  - I (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): ra=rs1, rw=rd, imm=sext(instr[31:20]).
  - S 0100011: ra=rs1, rb=rs2, imm=sext({instr[31:25], instr[11:7]}).
  - B 1100011: ra=rs1, rb=rs2, imm=sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U (LUI 0110111, AUIPC 0010111): rw=rd, imm=sext({instr[31:12], 12'b0}).
  - J 1101111: rw=rd, imm=sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Any register field unused by the format is driven to 0, never X. rw=0 means no writeback.
- Sign extension always replicates instr[31] up to XLEN-1.
- Illegal: opcode not listed, or instr[1:0]≠2'b11. Entry still passes through with out_illegal=1, fmt=NONE, imm/ra/rb/rw=0.
- illegal_count increments by 1 on each input handshake of an illegal word. It saturates at 2^CNT_W−1, is cleared only by rst, and is unaffected by flush.
- Priority: rst > flush > handshakes. A flush cycle drops all stored entries and any input offered that cycle. The counter still does not count that dropped input.

## Timing
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Latency: accepted instruction appears on out_* the next cycle (1 cycle) when the stage is empty.
- While out_valid && !out_ready, all out_* hold stable.
- Reset values: out_valid=0, all out_* data=0, out_fmt=NONE, out_illegal=0, illegal_count=0. in_ready=1 in the first cycle after rst deasserts.
- Simultaneous in and out transfer on a full output register: the new entry replaces the old one in the same edge, sustaining 1 instruction/cycle.
- Flush: next cycle out_valid=0 and in_ready=1.

## Configuration
- DECODE_SKID_EN defined: adds a 2-entry buffer (output register plus skid register).
  - in_ready is a register output equal to "skid empty", with no combinational path from out_ready.
  - When out_ready drops, one extra in-flight instruction is captured in skid. It is re-presented in order once out_ready returns.
- DECODE_SKID_EN undefined: single output register.
  - in_ready = !out_valid || out_ready (combinational).
  - Same latency, less storage.

## Test plan
- Send 0xFFF10093 (addi x1,x2,-1) with XLEN=32 → one cycle later out_imm=0xFFFFFFFF, ra=2, rb=0, rw=1, fmt=I, illegal=0.
- Send 0xFE000EE3 (beq x0,x0,-4) → out_imm=0xFFFFFFFC, fmt=B, rw=0. Repeat with XLEN=64 → imm=0xFFFFFFFFFFFFFFFC.
- Send 0x123450B7 (lui x1,0x12345) → out_imm=0x12345000, rw=1, ra=rb=0, fmt=U.
- Backpressure: stream PCs 0x0,0x4,0x8,0xC with out_ready low for cycles 2–4 → all four emerge in order, none duplicated. With DECODE_SKID_EN, in_ready falls exactly when both entries are full.
- Illegal: 0x00000000 → out_illegal=1, fmt=NONE, illegal_count=1. 300 consecutive illegals with CNT_W=8 → illegal_count=255.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, illegal_count unchanged. Then rst mid-stream → all outputs return to reset values.
